sdram_req_arbiter: RTL and testbench
====================================

// Module: sdram_req_arbiter
// PURPOSE
//  Two-client round-robin arbiter in front of the SDRAM controller request port (sdram_ctrl_if protocol).
//  Muxes client 0/1 requests onto one manager-side port and allows at most one outstanding read.
//  Routes rvalid/error back to the owning client; times out lost reads.
//  Sits between CPU/DMA masters (upstream) and the SDRAM controller (downstream).
// PARAMETERS
//  ADDR_WIDTH  32             request address width
//  DATA_WIDTH  32             data width
//  WORD_LEN    DATA_WIDTH/8   byte-enable width of wr
//  RD_TIMEOUT  64             cycles to wait for rvalid before error; 0 disables the timeout
// PORTS
//  clk            in   1           clock, all logic on rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  mN_wr          in   WORD_LEN    client N (N=0,1) write byte enables; nonzero = write request
//  mN_rd          in   1           client N read request
//  mN_addr        in   ADDR_WIDTH  client N address
//  mN_write_data  in   DATA_WIDTH  client N write data
//  mN_rdy         out  1           client N request accepted this cycle
//  mN_rvalid      out  1           client N read data valid
//  mN_error       out  1           client N error pulse
//  mN_read_data   out  DATA_WIDTH  client N read data (= s_read_data, unregistered)
//  s_wr           out  WORD_LEN    to controller: write byte enables
//  s_rd           out  1           to controller: read
//  s_addr         out  ADDR_WIDTH  to controller: address
//  s_write_data   out  DATA_WIDTH  to controller: write data
//  s_rdy          in   1           controller accepts the presented request
//  s_rvalid       in   1           controller read data valid
//  s_error        in   1           controller error
//  s_read_data    in   DATA_WIDTH  controller read data
// BEHAVIOUR
//  - Request from N = (|mN_wr)|mN_rd. Accept = request presented on s_ && s_rdy. Clients hold until mN_rdy.
//  - If a client asserts wr and rd together, the write wins: s_rd is forced to 0 and it is accepted as a write.
//  - State: IDLE, HOLD, RD_WAIT. Registers: grant g, last-accepted pointer lst, owner, timeout counter.
//  - IDLE: pick g. With one requester, g is that client. With both, g = ~lst.
//    Grant is combinational: g's request drives s_ that same cycle, and mN_rdy = s_rdy & (N==g).
//    On accept: a write returns to IDLE and sets lst=g; a read goes to RD_WAIT with owner=g, lst=g.
//    Without accept, go to HOLD and register g.
//  - HOLD: g frozen, so the other client cannot steal the grant. Accept moves to IDLE or RD_WAIT as above.
//    If g drops its request, go to IDLE with no accept and lst unchanged.
//  - RD_WAIT: s_wr=0, s_rd=0, m0_rdy=m1_rdy=0. On s_rvalid, m[owner]_rvalid=1 in that same cycle, then IDLE.
//    The counter increments each RD_WAIT cycle. At RD_TIMEOUT cycles (if nonzero), pulse m[owner]_error for 1 cycle, then IDLE.
//    s_rvalid and timeout in the same cycle: rvalid wins, no error.
//  - s_error is routed combinationally to m[owner]_error in RD_WAIT and to m[lst]_error otherwise.
//  - s_rvalid outside RD_WAIT is ignored (stale, e.g. after reset). Zero-latency pass-through; back-to-back accepts are allowed.
//  - Reset (async, any state): state=IDLE, lst=1 (client 0 wins the first tie), owner=0, counter=0.
//    Registered state drops any outstanding read. Held at reset, s_wr/s_rd/mN_rdy/mN_rvalid/mN_error=0.
//    s_addr/s_write_data=0 when no grant.
// TESTING
//  - Write pass-through: m0_wr=4'hF, addr=0x100, data=0xDEADBEEF, s_rdy=1 -> same cycle s_wr=F, s_addr=0x100, m0_rdy=1; m1_rdy=0.
//  - Tie round-robin: both clients post writes continuously, s_rdy=1 -> accepts alternate 0,1,0,1 starting with client 0 after reset.
//  - Hold lock: m1 read, s_rdy=0 for 3 cycles, m0 raises write meanwhile -> s_ stays m1's read; m1_rdy on the 4th cycle when s_rdy=1.
//  - Read routing: m1 read accepted; s_rvalid 5 cycles later with 0x12345678 -> m1_rvalid=1 with that data, m0_rvalid=0.
//    m0 request is blocked (m0_rdy=0) until then.
//  - Timeout: RD_TIMEOUT=8, m0 read accepted, no s_rvalid -> m0_error pulses 1 cycle after 8 RD_WAIT cycles; the next request is accepted.
//    Repeat with s_rvalid arriving on the timeout cycle -> rvalid, no error.
//  - Reset mid-read: assert rst_n=0 in RD_WAIT -> outputs 0 immediately.
//    After release, a stale s_rvalid gives no mN_rvalid, and a new m0 read is accepted normally.

Source files
------------

// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - two-client round-robin arbiter in front of the SDRAM controller request port
//
// Purpose: muxes client 0/1 requests onto one controller port. It allows at most one
// outstanding read, routes rvalid/error back to the owning client, and times out lost reads.
//
// Ports:
//   clk, rst_n              clock (rising edge) and asynchronous active-low reset
//   mN_wr/rd/addr/write_data  client N request; a nonzero mN_wr means a write, and the write wins over rd
//   mN_rdy                  client N request accepted this cycle
//   mN_rvalid/error         client N read data valid / error pulse
//   mN_read_data            client N read data (s_read_data passed straight through)
//   s_wr/rd/addr/write_data   request presented to the controller
//   s_rdy                   controller accepts the presented request
//   s_rvalid/error/read_data  controller read response and error
module sdram_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_LEN   = DATA_WIDTH / 8,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_LEN-1:0]   m0_wr,
    input  logic                  m0_rd,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic                  m0_rdy,
    output logic                  m0_rvalid,
    output logic                  m0_error,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    input  logic [WORD_LEN-1:0]   m1_wr,
    input  logic                  m1_rd,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic                  m1_rdy,
    output logic                  m1_rvalid,
    output logic                  m1_error,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic [WORD_LEN-1:0]   s_wr,
    output logic                  s_rd,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_write_data,
    input  logic                  s_rdy,
    input  logic                  s_rvalid,
    input  logic                  s_error,
    input  logic [DATA_WIDTH-1:0] s_read_data
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    // The counter must be able to reach RD_TIMEOUT itself.
    localparam int              CNT_W  = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(RD_TIMEOUT);

    logic [1:0]       state;
    logic             g_q;
    logic             lst;
    logic             owner;
    logic [CNT_W-1:0] cnt;

    logic                  req0, req1;
    logic                  g_sel;
    logic                  grant_vld;
    logic [WORD_LEN-1:0]   sel_wr;
    logic                  sel_rd;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  in_rd;
    logic                  timeout;

    assign req0 = (|m0_wr) | m0_rd;
    assign req1 = (|m1_wr) | m1_rd;

    // Grant is decided combinationally, so a lone requester passes through with no latency.
    // HOLD freezes the registered grant until that client is accepted or withdraws.
    always_comb begin
        g_sel     = g_q;
        grant_vld = 1'b0;
        case (state)
            IDLE: begin
                grant_vld = req0 | req1;
                g_sel     = (req0 & req1) ? ~lst : req1;
            end
            HOLD: begin
                g_sel     = g_q;
                grant_vld = g_q ? req1 : req0;
            end
            default: ;
        endcase
        // Outputs stay quiet while reset is held, even with clients requesting.
        if (!rst_n)
            grant_vld = 1'b0;
    end

    assign sel_wr   = g_sel ? m1_wr         : m0_wr;
    assign sel_rd   = g_sel ? m1_rd         : m0_rd;
    assign sel_addr = g_sel ? m1_addr       : m0_addr;
    assign sel_data = g_sel ? m1_write_data : m0_write_data;

    assign s_wr         = grant_vld ? sel_wr   : '0;
    assign s_rd         = grant_vld & sel_rd & ~(|sel_wr);
    assign s_addr       = grant_vld ? sel_addr : '0;
    assign s_write_data = grant_vld ? sel_data : '0;

    assign accept = grant_vld & s_rdy;
    assign m0_rdy = accept & ~g_sel;
    assign m1_rdy = accept & g_sel;

    assign in_rd   = (state == RD_WAIT) & rst_n;
    assign timeout = in_rd && (RD_TIMEOUT != 0) && (cnt == TO_VAL);

    // If rvalid arrives on the timeout cycle, it suppresses the timeout error.
    assign m0_rvalid = in_rd & s_rvalid & ~owner;
    assign m1_rvalid = in_rd & s_rvalid & owner;
    assign m0_error  = rst_n & (in_rd ? (~owner & (s_error | (timeout & ~s_rvalid)))
                                      : (~lst & s_error));
    assign m1_error  = rst_n & (in_rd ? (owner & (s_error | (timeout & ~s_rvalid)))
                                      : (lst & s_error));

    assign m0_read_data = s_read_data;
    assign m1_read_data = s_read_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            g_q   <= 1'b0;
            lst   <= 1'b1;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (grant_vld) begin
                        if (accept) begin
                            lst <= g_sel;
                            if (s_rd) begin
                                state <= RD_WAIT;
                                owner <= g_sel;
                                cnt   <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= HOLD;
                            g_q   <= g_sel;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (s_rvalid || timeout)
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb/tb_sdram_req_arbiter.sv - directed self-checking bench for sdram_req_arbiter
module tb_sdram_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  m0_wr, m1_wr, s_wr;
    logic        m0_rd, m1_rd, s_rd;
    logic [31:0] m0_addr, m1_addr, s_addr;
    logic [31:0] m0_write_data, m1_write_data, s_write_data;
    logic        m0_rdy, m1_rdy, m0_rvalid, m1_rvalid, m0_error, m1_error;
    logic [31:0] m0_read_data, m1_read_data, s_read_data;
    logic        s_rdy, s_rvalid, s_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_req_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORD_LEN(4), .RD_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_write_data(m0_write_data),
        .m0_rdy(m0_rdy), .m0_rvalid(m0_rvalid), .m0_error(m0_error), .m0_read_data(m0_read_data),
        .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_write_data(m1_write_data),
        .m1_rdy(m1_rdy), .m1_rvalid(m1_rvalid), .m1_error(m1_error), .m1_read_data(m1_read_data),
        .s_wr(s_wr), .s_rd(s_rd), .s_addr(s_addr), .s_write_data(s_write_data),
        .s_rdy(s_rdy), .s_rvalid(s_rvalid), .s_error(s_error), .s_read_data(s_read_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        m0_wr = 4'h0; m0_rd = 1'b0; m0_addr = '0; m0_write_data = '0;
        m1_wr = 4'h0; m1_rd = 1'b0; m1_addr = '0; m1_write_data = '0;
        s_rdy = 1'b0; s_rvalid = 1'b0; s_error = 1'b0; s_read_data = '0;
    endtask

    // Advance to just after the next rising edge; inputs are driven here, checks follow after #1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        m0_wr = 4'hF; s_rdy = 1'b1;
        #3;
        chk("rst_s_wr", s_wr, 4'h0);
        chk("rst_m0_rdy", m0_rdy, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        cyc(); cyc();
        quiet();
        rst_n = 1'b1;
        cyc();

        // Tie: both write continuously; client 0 wins first after reset
        m0_wr = 4'hF; m1_wr = 4'hF; s_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_m0_rdy", m0_rdy, (i % 2 == 0));
            chk("tie_m1_rdy", m1_rdy, (i % 2 == 1));
            cyc();
        end
        quiet();

        // Write pass-through
        m0_wr = 4'hF; m0_addr = 32'h100; m0_write_data = 32'hDEADBEEF; s_rdy = 1'b1;
        #1;
        chk("wr_s_wr", s_wr, 4'hF);
        chk("wr_s_addr", s_addr, 32'h100);
        chk("wr_s_data", s_write_data, 32'hDEADBEEF);
        chk("wr_m0_rdy", m0_rdy, 1'b1);
        chk("wr_m1_rdy", m1_rdy, 1'b0);
        cyc();
        quiet();

        // Hold lock: m1 read stalls 3 cycles while m0 raises a write
        m1_rd = 1'b1; m1_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_s_rd", s_rd, 1'b1);
            chk("hold_s_addr", s_addr, 32'h200);
            chk("hold_m1_rdy", m1_rdy, 1'b0);
            cyc();
            m0_wr = 4'hF; m0_addr = 32'h300;
        end
        s_rdy = 1'b1;
        #1;
        chk("hold_s_wr", s_wr, 4'h0);
        chk("hold_acc_m1", m1_rdy, 1'b1);
        chk("hold_acc_m0", m0_rdy, 1'b0);
        cyc();
        m1_rd = 1'b0;

        // Read routing: rvalid 5 cycles after accept, m0 blocked until then
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rdw_m0_rdy", m0_rdy, 1'b0);
            chk("rdw_s_wr", s_wr, 4'h0);
            cyc();
        end
        s_rvalid = 1'b1; s_read_data = 32'h12345678;
        #1;
        chk("rv_m1_rvalid", m1_rvalid, 1'b1);
        chk("rv_m1_data", m1_read_data, 32'h12345678);
        chk("rv_m0_rvalid", m0_rvalid, 1'b0);
        chk("rv_m0_rdy", m0_rdy, 1'b0);
        cyc();
        s_rvalid = 1'b0;
        #1;
        chk("after_rv_m0_rdy", m0_rdy, 1'b1);
        cyc();
        quiet();

        // Timeout: error in the cycle after 8 silent RD_WAIT cycles
        m0_rd = 1'b1; m0_addr = 32'h400; s_rdy = 1'b1;
        #1;
        chk("to_acc", m0_rdy, 1'b1);
        chk("to_s_rd", s_rd, 1'b1);
        cyc();
        quiet();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to_early_err", m0_error, 1'b0);
            cyc();
        end
        #1;
        chk("to_m0_error", m0_error, 1'b1);
        chk("to_m1_error", m1_error, 1'b0);
        cyc();
        m1_wr = 4'h1; s_rdy = 1'b1;
        #1;
        chk("to_err_gone", m0_error, 1'b0);
        chk("to_next_acc", m1_rdy, 1'b1);
        cyc();
        quiet();

        // Timeout again, with rvalid on the timeout cycle
        m0_rd = 1'b1; s_rdy = 1'b1;
        cyc();
        quiet();
        for (int i = 0; i < 8; i++) cyc();
        s_rvalid = 1'b1; s_read_data = 32'hCAFEF00D;
        #1;
        chk("tov_rvalid", m0_rvalid, 1'b1);
        chk("tov_no_err", m0_error, 1'b0);
        cyc();
        quiet();

        // s_error outside RD_WAIT goes to the last-accepted client (m0)
        s_error = 1'b1;
        #1;
        chk("serr_m0", m0_error, 1'b1);
        chk("serr_m1", m1_error, 1'b0);
        cyc();
        quiet();

        // wr and rd together: write wins, stays out of RD_WAIT
        m1_wr = 4'h3; m1_rd = 1'b1; s_rdy = 1'b1;
        #1;
        chk("wrd_s_rd", s_rd, 1'b0);
        chk("wrd_s_wr", s_wr, 4'h3);
        chk("wrd_m1_rdy", m1_rdy, 1'b1);
        cyc();
        m1_rd = 1'b0;
        #1;
        chk("wrd_b2b", m1_rdy, 1'b1);
        cyc();
        quiet();

        // Reset during RD_WAIT
        m0_rd = 1'b1; s_rdy = 1'b1;
        cyc();
        quiet();
        cyc();
        m0_wr = 4'hF; s_rdy = 1'b1; s_rvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mrst_rvalid", m0_rvalid, 1'b0);
        chk("mrst_s_wr", s_wr, 4'h0);
        chk("mrst_m0_rdy", m0_rdy, 1'b0);
        cyc();
        quiet();
        rst_n = 1'b1;
        s_rvalid = 1'b1;
        #1;
        chk("stale_m0_rv", m0_rvalid, 1'b0);
        chk("stale_m1_rv", m1_rvalid, 1'b0);
        cyc();
        quiet();
        m0_rd = 1'b1; s_rdy = 1'b1;
        #1;
        chk("post_rd_acc", m0_rdy, 1'b1);
        chk("post_s_rd", s_rd, 1'b1);
        cyc();
        quiet();
        s_rvalid = 1'b1;
        #1;
        chk("post_rvalid", m0_rvalid, 1'b1);
        cyc();
        quiet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
